video_stream_capture: RTL and testbench
=======================================

VIDEO_STREAM_CAPTURE -- requirements
Module: video_stream_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 720, active lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 20, frame-memory write address width.
REQ-004 pclk  in  1  pixel clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  capture enable.
REQ-007 in_vsync  in  1  frame sync; rising edge marks frame start.
REQ-008 in_href  in  1  active-pixel qualifier.
REQ-009 in_y  in  8  luma sample.
REQ-010 wr_en  out  1  frame-memory write strobe.
REQ-011 wr_addr  out  ADDR_W  write address = line*WIDTH+col.
REQ-012 wr_data  out  8  captured sample.
REQ-013 frame_done  out  1  one-cycle pulse when a frame closes.
REQ-014 frame_ok  out  1  valid with frame_done; 1 = geometry exact, no errors.
REQ-015 err_width, err_height, err_stray  out  1 each  per-frame error flags, valid with frame_done.
REQ-016 pix_cnt  out  21  accepted pixels in last frame; y_sum out 28; black_cnt out 21; frame_cnt out 16.

Function
REQ-017 States: IDLE, WAIT_VS, ACTIVE, DONE.
REQ-018 IDLE -> WAIT_VS when enable=1; any state -> IDLE when enable=0, no frame_done, counters cleared.
REQ-019 WAIT_VS -> ACTIVE on in_vsync rising edge (registered edge detect); col, line, wr_addr, per-frame stats and flags cleared on entry.
REQ-020 In ACTIVE, each cycle with in_href=1 and col<WIDTH: wr_en=1, wr_data=in_y, wr_addr incremented by 1 after use (no multiplier), col+1, pix_cnt+1.
REQ-021 Write port latency exactly one cycle from in_href/in_y sample to wr_en/wr_data.
REQ-022 in_href=1 with col>=WIDTH: no write, err_width set.
REQ-023 On in_href falling edge in ACTIVE: col!=WIDTH sets err_width; col reset to 0; line+1.
REQ-024 When line reaches HEIGHT (falling edge of HEIGHT-th line): ACTIVE -> DONE.
REQ-025 in_vsync rising edge in ACTIVE with line<HEIGHT: err_height set, DONE entered; the same edge also re-arms, so DONE -> ACTIVE directly (frame not lost).
REQ-026 in_href=1 while in WAIT_VS: no write, err_stray latched and reported with next frame.
REQ-027 DONE lasts one cycle: frame_done=1, frame_ok=!(err_width|err_height|err_stray), result outputs updated, frame_cnt+1 (wraps 65535->0); then WAIT_VS unless REQ-025 applies.
REQ-028 Result outputs hold last published values until next DONE.
REQ-029 y_sum accumulates in_y of accepted pixels; black_cnt counts accepted pixels with in_y==0; no saturation needed (max 235008000 < 2^28).

Reset
REQ-030 rst=1: state IDLE; wr_en, frame_done, frame_ok, error flags, wr_addr, wr_data, pix_cnt, y_sum, black_cnt, frame_cnt all 0.
REQ-031 rst mid-frame: capture aborted, no frame_done, next capture requires new vsync rising edge after rst release.

Configuration
REQ-032 Macro CAPTURE_STATS_EN defined: y_sum and black_cnt accumulators built per REQ-029.
REQ-033 Macro undefined: accumulators absent, y_sum and black_cnt tied to 0; all other behaviour unchanged.

Structure
REQ-034 Package capture_pkg SHALL hold the state enum and widths PIX_CNT_W=21, Y_SUM_W=28, FRAME_CNT_W=16.
REQ-035 Accumulators SHALL live in sub-module capture_stats, instantiated only under CAPTURE_STATS_EN.

Verification (bench uses WIDTH=8, HEIGHT=4, ADDR_W=6)
REQ-036 Clean frame, 4 lines x 8 px, in_y=col*10 -> 32 writes, addr 0..31, one cycle late; frame_done with frame_ok=1, pix_cnt=32, y_sum=1120, black_cnt=4, frame_cnt=1.
REQ-037 Line 2 carries 10 px -> px 9,10 not written, err_width=1, frame_ok=0, pix_cnt=32.
REQ-038 vsync rises after 3 lines -> frame_done with err_height=1, pix_cnt=24; following clean frame captured immediately, frame_ok=1.
REQ-039 href pulse of 3 cycles in WAIT_VS -> no writes; next frame reports err_stray=1, frame_ok=0.
REQ-040 rst asserted after 13 px -> all outputs 0, no frame_done; enable=0 mid-frame -> IDLE, no frame_done.
REQ-041 Build without CAPTURE_STATS_EN, repeat REQ-036 -> y_sum=0, black_cnt=0, other results identical.

Source files
------------

// File: rtl/video_stream_capture_pkg.sv
// Shared types and widths for the video stream capture block.
package capture_pkg;

  // Capture controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  localparam int PIX_CNT_W   = 21;
  localparam int Y_SUM_W     = 28;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/video_stream_capture_if.sv
// Video input and frame-memory write port bundle for video_stream_capture.
//
// Handshake: there is no backpressure on either side. A sample is
// qualified by in_href=1 in the cycle it is presented; a write is one
// cycle long and qualified by wr_en=1, with wr_addr/wr_data valid in that
// same cycle. The frame memory must accept every strobe.
interface video_stream_capture_if #(
  parameter int ADDR_W = 20
) ();
  logic              in_vsync;
  logic              in_href;
  logic [7:0]        in_y;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  // Video source / memory sink side (testbench or upstream sensor).
  modport master (
    output in_vsync, in_href, in_y,
    input  wr_en, wr_addr, wr_data
  );

  // Capture block side.
  modport slave (
    input  in_vsync, in_href, in_y,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/video_stream_capture_stats.sv
// Per-frame luma statistics: running sum of accepted samples and count of
// black (zero) samples, published to holding registers at frame close.
module capture_stats
  import capture_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 acc_i,
  input  logic [7:0]           y_i,
  input  logic                 pub_i,
  output logic [Y_SUM_W-1:0]   y_sum_o,
  output logic [PIX_CNT_W-1:0] black_cnt_o
);

  logic [Y_SUM_W-1:0]   sum_q;
  logic [PIX_CNT_W-1:0] blk_q;
  logic [Y_SUM_W-1:0]   y_sum_q;
  logic [PIX_CNT_W-1:0] black_q;

  // Accumulate accepted samples; publish the totals when the frame closes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q   <= '0;
      blk_q   <= '0;
      y_sum_q <= '0;
      black_q <= '0;
    end else begin
      if (clr_i) begin
        sum_q <= '0;
        blk_q <= '0;
      end else if (acc_i) begin
        sum_q <= sum_q + Y_SUM_W'(y_i);
        if (y_i == 8'd0) blk_q <= blk_q + PIX_CNT_W'(1);
      end
      if (pub_i) begin
        y_sum_q <= sum_q;
        black_q <= blk_q;
      end
    end
  end

  assign y_sum_o     = y_sum_q;
  assign black_cnt_o = black_q;

endmodule

// File: rtl/video_stream_capture.sv
// Video stream capture: writes an 8-bit luma frame into memory at
// line*WIDTH+col, checks frame geometry and reports per-frame results.
// Optional build macro CAPTURE_STATS_EN adds luma sum / black pixel stats;
// without it y_sum and black_cnt read as zero.
module video_stream_capture
  import capture_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int ADDR_W = 20
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   enable,
  video_stream_capture_if.slave  vid,
  output logic                   frame_done,
  output logic                   frame_ok,
  output logic                   err_width,
  output logic                   err_height,
  output logic                   err_stray,
  output logic [PIX_CNT_W-1:0]   pix_cnt,
  output logic [Y_SUM_W-1:0]     y_sum,
  output logic [PIX_CNT_W-1:0]   black_cnt,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output cap_state_e             dbg_state
);

  localparam int COL_W  = $clog2(WIDTH + 1);
  localparam int LINE_W = $clog2(HEIGHT + 1);
  localparam logic [COL_W-1:0]  WIDTH_C     = COL_W'(WIDTH);
  localparam logic [LINE_W-1:0] HEIGHT_C    = LINE_W'(HEIGHT);
  localparam logic [LINE_W-1:0] LAST_LINE_C = LINE_W'(HEIGHT - 1);

  cap_state_e             state_q;
  logic                   vs_q, href_q;
  logic [COL_W-1:0]       col_q;
  logic [LINE_W-1:0]      line_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [PIX_CNT_W-1:0]   pix_q;
  logic                   err_w_q, stray_q, rearm_q;

  logic                   wr_en_q;
  logic [ADDR_W-1:0]      wr_addr_q;
  logic [7:0]             wr_data_q;
  logic                   frame_done_q, frame_ok_q;
  logic                   err_width_q, err_height_q, err_stray_q;
  logic [PIX_CNT_W-1:0]   pix_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic vs_rise, href_fall, in_active, early_vs;
  logic accept, overrun, line_end, short_line, last_line;
  logic go_done, frame_start, width_err_fin;

  // Frame events decoded from the live inputs and the registered edges.
  always_comb begin
    vs_rise    = vid.in_vsync & ~vs_q;
    href_fall  = ~vid.in_href & href_q;
    in_active  = (state_q == ST_ACTIVE);
    // A vsync edge before all lines arrived closes the frame short; the
    // cycle carrying that edge takes no pixel.
    early_vs   = in_active & vs_rise & (line_q < HEIGHT_C);
    accept     = in_active & ~early_vs & vid.in_href & (col_q < WIDTH_C);
    overrun    = in_active & ~early_vs & vid.in_href & (col_q >= WIDTH_C);
    line_end   = in_active & ~early_vs & href_fall;
    short_line = line_end & (col_q != WIDTH_C);
    last_line  = line_end & (line_q == LAST_LINE_C);
    go_done    = enable & (early_vs | last_line);
    frame_start = enable & (((state_q == ST_WAIT_VS) & vs_rise) |
                            ((state_q == ST_DONE) & rearm_q));
    width_err_fin = err_w_q | short_line;
  end

  // Capture FSM with registered write port and result registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vs_q         <= 1'b0;
      href_q       <= 1'b0;
      col_q        <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      pix_q        <= '0;
      err_w_q      <= 1'b0;
      stray_q      <= 1'b0;
      rearm_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_width_q  <= 1'b0;
      err_height_q <= 1'b0;
      err_stray_q  <= 1'b0;
      pix_cnt_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      vs_q         <= vid.in_vsync;
      href_q       <= vid.in_href;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (!enable) begin
        // Disable aborts any frame in progress without reporting it.
        state_q <= ST_IDLE;
        col_q   <= '0;
        line_q  <= '0;
        addr_q  <= '0;
        pix_q   <= '0;
        err_w_q <= 1'b0;
        stray_q <= 1'b0;
        rearm_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE:    state_q <= ST_WAIT_VS;
          ST_WAIT_VS: begin
            if (vs_rise) state_q <= ST_ACTIVE;
            else if (vid.in_href) stray_q <= 1'b1;
          end
          ST_ACTIVE:  if (go_done) state_q <= ST_DONE;
          ST_DONE:    state_q <= rearm_q ? ST_ACTIVE : ST_WAIT_VS;
          default:    state_q <= ST_IDLE;
        endcase

        if (frame_start) begin
          col_q     <= '0;
          line_q    <= '0;
          addr_q    <= '0;
          pix_q     <= '0;
          err_w_q   <= 1'b0;
          rearm_q   <= 1'b0;
          wr_addr_q <= '0;
        end

        if (accept) begin
          wr_en_q   <= 1'b1;
          wr_data_q <= vid.in_y;
          wr_addr_q <= addr_q;
          addr_q    <= addr_q + ADDR_W'(1);
          col_q     <= col_q + COL_W'(1);
          pix_q     <= pix_q + PIX_CNT_W'(1);
        end

        if (overrun) err_w_q <= 1'b1;

        if (line_end) begin
          col_q  <= '0;
          line_q <= line_q + LINE_W'(1);
          if (short_line) err_w_q <= 1'b1;
        end

        if (go_done) begin
          frame_done_q <= 1'b1;
          err_width_q  <= width_err_fin;
          err_height_q <= early_vs;
          err_stray_q  <= stray_q;
          frame_ok_q   <= ~(width_err_fin | early_vs | stray_q);
          pix_cnt_q    <= pix_q;
          frame_cnt_q  <= frame_cnt_q + FRAME_CNT_W'(1);
          stray_q      <= 1'b0;
          rearm_q      <= early_vs;
        end
      end
    end
  end

`ifdef CAPTURE_STATS_EN
  capture_stats u_stats (
    .clk_i       (pclk),
    .rst_i       (rst),
    .clr_i       (~enable | frame_start),
    .acc_i       (accept),
    .y_i         (vid.in_y),
    .pub_i       (go_done),
    .y_sum_o     (y_sum),
    .black_cnt_o (black_cnt)
  );
`else
  assign y_sum     = '0;
  assign black_cnt = '0;
`endif

  assign vid.wr_en   = wr_en_q;
  assign vid.wr_addr = wr_addr_q;
  assign vid.wr_data = wr_data_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign err_width   = err_width_q;
  assign err_height  = err_height_q;
  assign err_stray   = err_stray_q;
  assign pix_cnt     = pix_cnt_q;
  assign frame_cnt   = frame_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_video_stream_capture.sv
// Testbench for video_stream_capture (WIDTH=8, HEIGHT=4, ADDR_W=6).
module tb_video_stream_capture;
  import capture_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 6;
  localparam int WQ_W = AW + 8 + 32;
  localparam int FQ_W = 4 + PIX_CNT_W + Y_SUM_W + PIX_CNT_W + FRAME_CNT_W;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic rst;
  logic enable;
  always #5 pclk = ~pclk;

  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  video_stream_capture_if #(.ADDR_W(AW)) vif ();

  logic                   frame_done, frame_ok;
  logic                   err_width, err_height, err_stray;
  logic [PIX_CNT_W-1:0]   pix_cnt;
  logic [Y_SUM_W-1:0]     y_sum;
  logic [PIX_CNT_W-1:0]   black_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  cap_state_e             dbg_state;

  video_stream_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .enable     (enable),
    .vid        (vif.slave),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_width  (err_width),
    .err_height (err_height),
    .err_stray  (err_stray),
    .pix_cnt    (pix_cnt),
    .y_sum      (y_sum),
    .black_cnt  (black_cnt),
    .frame_cnt  (frame_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [WQ_W-1:0] exp_q[$];   // {addr, data, cycle}
  logic [FQ_W-1:0] exp_fq[$];  // {ok, ew, eh, es, pix, ysum, black, fcnt}
  int n_vec  = 0;
  int n_miss = 0;
  int wbase  = 0;

  function automatic int ys(input int v);
`ifdef CAPTURE_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic void push_frame(input logic ok, ew, eh, es,
                                     input int pix, ysum, blk, fcnt);
    exp_fq.push_back({ok, ew, eh, es, PIX_CNT_W'(pix), Y_SUM_W'(ys(ysum)),
                      PIX_CNT_W'(ys(blk)), FRAME_CNT_W'(fcnt)});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write and every frame_done is matched against the queues.
  always @(negedge pclk) begin
    logic [WQ_W-1:0] we;
    logic [FQ_W-1:0] fe;
    logic [FQ_W-1:0] fa;
    if (vif.wr_en === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_write: addr %0d data %0d, none expected",
                 vif.wr_addr, vif.wr_data);
      end else begin
        we = exp_q.pop_front();
        if ({vif.wr_addr, vif.wr_data, cyc} !== we) begin
          n_miss++;
          $display("FAIL write: got addr %0d data %0d cyc %0d expected addr %0d data %0d cyc %0d",
                   vif.wr_addr, vif.wr_data, cyc, we[WQ_W-1 -: AW], we[39:32], we[31:0]);
        end
      end
    end
    if (frame_done === 1'b1) begin
      n_vec++;
      fa = {frame_ok, err_width, err_height, err_stray, pix_cnt, y_sum, black_cnt, frame_cnt};
      if (exp_fq.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_frame_done: result %h", fa);
      end else begin
        fe = exp_fq.pop_front();
        if (fa !== fe) begin
          n_miss++;
          $display("FAIL frame_result: got ok/ew/eh/es=%b pix %0d ysum %0d blk %0d fcnt %0d expected ok/ew/eh/es=%b pix %0d ysum %0d blk %0d fcnt %0d",
                   fa[FQ_W-1 -: 4], pix_cnt, y_sum, black_cnt, frame_cnt,
                   fe[FQ_W-1 -: 4], fe[FQ_W-5 -: PIX_CNT_W],
                   fe[FRAME_CNT_W+PIX_CNT_W +: Y_SUM_W],
                   fe[FRAME_CNT_W +: PIX_CNT_W], fe[FRAME_CNT_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic vsync_pulse();
    vif.in_vsync = 1'b1;
    idle(2);
    vif.in_vsync = 1'b0;
    idle(3);
  endtask

  // n samples with in_y = col*10; only the first W are expected in memory.
  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      vif.in_href = 1'b1;
      vif.in_y    = 8'(i * 10);
      if (i < W) exp_q.push_back({AW'(wbase + i), 8'(i * 10), cyc + 1});
      tick();
    end
    vif.in_href = 1'b0;
    wbase += (n < W) ? n : W;
    idle(4);
  endtask

  task automatic send_frame(input int lines);
    for (int l = 0; l < lines; l++) send_line(W);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"},      32'(vif.wr_en), 0);
    chk({tag, "_wr_addr"},    32'(vif.wr_addr), 0);
    chk({tag, "_wr_data"},    32'(vif.wr_data), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_ok"},   32'(frame_ok), 0);
    chk({tag, "_errs"},       32'({err_width, err_height, err_stray}), 0);
    chk({tag, "_pix_cnt"},    32'(pix_cnt), 0);
    chk({tag, "_y_sum"},      32'(y_sum), 0);
    chk({tag, "_black_cnt"},  32'(black_cnt), 0);
    chk({tag, "_frame_cnt"},  32'(frame_cnt), 0);
    chk({tag, "_state"},      32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Watchdog bounding the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    enable = 1'b0;
    vif.in_vsync = 1'b0;
    vif.in_href  = 1'b0;
    vif.in_y     = 8'd0;
    idle(3);
    check_zero("reset");
    rst = 1'b0;
    enable = 1'b1;
    idle(2);
    chk("armed_state", 32'(dbg_state), 32'(ST_WAIT_VS));

    // Clean frame.
    push_frame(1'b1, 1'b0, 1'b0, 1'b0, 32, 1120, 4, 1);
    wbase = 0;
    vsync_pulse();
    send_frame(H);
    idle(3);
    chk("hold_pix_cnt", 32'(pix_cnt), 32);
    chk("hold_frame_ok", 32'(frame_ok), 1);

    // Second line too long.
    push_frame(1'b0, 1'b1, 1'b0, 1'b0, 32, 1120, 4, 2);
    wbase = 0;
    vsync_pulse();
    send_line(W);
    send_line(10);
    send_line(W);
    send_line(W);

    // Short frame closed by vsync, next frame captured on that same edge.
    push_frame(1'b0, 1'b0, 1'b1, 1'b0, 24, 840, 3, 3);
    push_frame(1'b1, 1'b0, 1'b0, 1'b0, 32, 1120, 4, 4);
    wbase = 0;
    vsync_pulse();
    send_frame(3);
    wbase = 0;
    vsync_pulse();
    send_frame(H);

    // Stray href while waiting for vsync.
    idle(2);
    vif.in_href = 1'b1;
    idle(3);
    vif.in_href = 1'b0;
    idle(3);
    chk("stray_state", 32'(dbg_state), 32'(ST_WAIT_VS));
    push_frame(1'b0, 1'b0, 1'b0, 1'b1, 32, 1120, 4, 5);
    wbase = 0;
    vsync_pulse();
    send_frame(H);

    // Reset after 13 pixels.
    wbase = 0;
    vsync_pulse();
    send_line(W);
    for (int i = 0; i < 5; i++) begin
      vif.in_href = 1'b1;
      vif.in_y    = 8'(i * 10);
      exp_q.push_back({AW'(wbase + i), 8'(i * 10), cyc + 1});
      tick();
    end
    vif.in_href = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_zero("mid_rst");
    rst = 1'b0;
    idle(3);

    // Disable mid-frame.
    wbase = 0;
    vsync_pulse();
    send_line(W);
    enable = 1'b0;
    idle(2);
    chk("disable_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("disable_no_done", 32'(frame_done), 0);
    enable = 1'b1;
    idle(2);

    // Clean frame after reset and disable; frame count restarted by reset.
    push_frame(1'b1, 1'b0, 1'b0, 1'b0, 32, 1120, 4, 1);
    wbase = 0;
    vsync_pulse();
    send_frame(H);
    idle(5);

    chk("writes_drained", 32'(exp_q.size()), 0);
    chk("frames_drained", 32'(exp_fq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
